// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M-style multiply/divide unit. One multiplier bit (shift-add)
//   or one quotient bit (restoring divide) is produced per clock, so a normal
//   operation completes with done in the XLEN+1-th cycle after the accepting
//   edge. Divide-by-zero and signed-overflow divides skip the iteration and
//   complete in the first cycle.
//
// Ports
//   clk     in   1     clock, all state updates on the rising edge
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request, sampled only while idle
//   funct3  in   3     000 MUL 001 MULH 010 MULHSU 011 MULHU
//                      100 DIV 101 DIVU 110 REM 111 REMU
//   op_a    in   XLEN  rs1 / dividend / multiplicand
//   op_b    in   XLEN  rs2 / divisor / multiplier
//   flush   in   1     abort any in-flight operation
//   busy    out  1     high while an operation is in flight (CALC or DONE)
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  last completed result, held until overwritten
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [2:0]        fn_r;
   // multiply: running product; divide: {partial remainder, dividend/quotient}
   logic [2*XLEN-1:0] acc_r;
   // multiply: shifted multiplicand (unused for divide)
   logic [2*XLEN-1:0] op1_r;
   // multiply: remaining multiplier bits; divide: divisor magnitude
   logic [XLEN-1:0]   op2_r;
   logic              b_sgn_r;
   logic              neg_q_r;
   logic              neg_rem_r;
   logic [XLEN-1:0]   result_r;
   logic              done_r;

   logic              accept_s;
   logic              is_div_s;
   logic              div0_s;
   logic              ovf_s;
   logic              special_s;
   logic              last_s;
   logic [XLEN-1:0]   spec_res_s;

   logic              sdiv_s;
   logic              a_sgn_s;
   logic              b_sgn_s;
   logic [XLEN-1:0]   mag_a_s;
   logic [XLEN-1:0]   mag_b_s;
   logic [2*XLEN-1:0] mcand_init_s;

   logic [XLEN:0]     trial_s;
   logic [2*XLEN-1:0] addend_s;
   logic [2*XLEN-1:0] acc_step_s;
   logic [2*XLEN-1:0] op1_step_s;
   logic [XLEN-1:0]   op2_step_s;
   logic [XLEN-1:0]   final_res_s;

   // Select and sign-correct the architectural result from the final accumulator.
   function automatic logic [XLEN-1:0] final_result(
      input logic [2:0]        fn,
      input logic [2*XLEN-1:0] acc,
      input logic              neg_q,
      input logic              neg_rem
   );
      logic [XLEN-1:0] lo;
      logic [XLEN-1:0] hi;
      lo = acc[XLEN-1:0];
      hi = acc[2*XLEN-1:XLEN];
      case (fn)
         3'b000:                 final_result = lo;
         3'b001, 3'b010, 3'b011: final_result = hi;
         3'b100, 3'b101:         final_result = neg_q   ? ({XLEN{1'b0}} - lo) : lo;
         3'b110, 3'b111:         final_result = neg_rem ? ({XLEN{1'b0}} - hi) : hi;
         default:                final_result = {XLEN{1'b0}};
      endcase
   endfunction

   assign busy   = (state_r != IDLE);
   assign done   = done_r;
   assign result = result_r;

   // Request decode, including the two divide cases that bypass iteration.
   always_comb begin
      accept_s  = (state_r == IDLE) && start && !flush;
      is_div_s  = funct3[2];
      div0_s    = is_div_s && (op_b == {XLEN{1'b0}});
      ovf_s     = is_div_s && !funct3[0] && (op_a == INT_MIN) && (op_b == {XLEN{1'b1}});
      special_s = div0_s || ovf_s;
      last_s    = (cnt_r == CNT_LAST);
      if (div0_s) begin
         spec_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
      end else if (ovf_s) begin
         spec_res_s = funct3[1] ? {XLEN{1'b0}} : op_a;
      end else begin
         spec_res_s = {XLEN{1'b0}};
      end
   end

   // Operand preparation at accept: extension for multiply, magnitudes for divide.
   always_comb begin
      sdiv_s  = funct3[2] && !funct3[0];
      a_sgn_s = (funct3 == 3'b001) || (funct3 == 3'b010);
      b_sgn_s = (funct3 == 3'b001);
      if (sdiv_s && op_a[XLEN-1]) begin
         mag_a_s = {XLEN{1'b0}} - op_a;
      end else begin
         mag_a_s = op_a;
      end
      if (sdiv_s && op_b[XLEN-1]) begin
         mag_b_s = {XLEN{1'b0}} - op_b;
      end else begin
         mag_b_s = op_b;
      end
      if (a_sgn_s) begin
         mcand_init_s = {{XLEN{op_a[XLEN-1]}}, op_a};
      end else begin
         mcand_init_s = {{XLEN{1'b0}}, op_a};
      end
   end

   // One iteration step. A signed multiplier's top bit carries negative
   // weight, so the last partial product is subtracted instead of added.
   always_comb begin
      acc_step_s = acc_r;
      op1_step_s = op1_r;
      op2_step_s = op2_r;
      trial_s    = acc_r[2*XLEN-1:XLEN-1] - {1'b0, op2_r};
      addend_s   = op2_r[0] ? op1_r : {(2*XLEN){1'b0}};
      if (fn_r[2]) begin
         if (!trial_s[XLEN]) begin
            acc_step_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
         end else begin
            acc_step_s = {acc_r[2*XLEN-2:0], 1'b0};
         end
      end else begin
         if (last_s && b_sgn_r) begin
            acc_step_s = acc_r - addend_s;
         end else begin
            acc_step_s = acc_r + addend_s;
         end
         op1_step_s = {op1_r[2*XLEN-2:0], 1'b0};
         op2_step_s = {1'b0, op2_r[XLEN-1:1]};
      end
      final_res_s = final_result(fn_r, acc_step_s, neg_q_r, neg_rem_r);
   end

   // Next-state logic; flush always wins over start and over completion.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = special_s ? DONE : CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CALC;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch at accept and per-cycle iteration while calculating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= {CNT_W{1'b0}};
         fn_r      <= 3'b000;
         acc_r     <= {(2*XLEN){1'b0}};
         op1_r     <= {(2*XLEN){1'b0}};
         op2_r     <= {XLEN{1'b0}};
         b_sgn_r   <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  fn_r  <= funct3;
                  cnt_r <= {CNT_W{1'b0}};
                  if (funct3[2]) begin
                     acc_r     <= {{XLEN{1'b0}}, mag_a_s};
                     op1_r     <= {(2*XLEN){1'b0}};
                     op2_r     <= mag_b_s;
                     b_sgn_r   <= 1'b0;
                     neg_q_r   <= sdiv_s && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                     neg_rem_r <= sdiv_s && op_a[XLEN-1];
                  end else begin
                     acc_r     <= {(2*XLEN){1'b0}};
                     op1_r     <= mcand_init_s;
                     op2_r     <= op_b;
                     b_sgn_r   <= b_sgn_s;
                     neg_q_r   <= 1'b0;
                     neg_rem_r <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (!flush) begin
                  acc_r <= acc_step_s;
                  op1_r <= op1_step_s;
                  op2_r <= op2_step_s;
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Result and done pulse, loaded only on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= {XLEN{1'b0}};
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s && special_s) begin
                  result_r <= spec_res_s;
                  done_r   <= 1'b1;
               end
            end
            CALC: begin
               if (!flush && last_s) begin
                  result_r <= final_res_s;
                  done_r   <= 1'b1;
               end
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

endmodule
